// File: rtl/issue_ctrl_if.sv
// Decode/execute/writeback signals seen by the issue controller, plus the
// instruction-id encodings shared by the decoder and the controller.
package issue_ctrl_pkg;
  // Mirrors the core's decoded instruction-id table.
  localparam logic [6:0] I_BUBBLE  = 7'd0;
  localparam logic [6:0] I_INVALID = 7'd1;
  localparam logic [6:0] I_ADD     = 7'd2;
  localparam logic [6:0] I_SUB     = 7'd3;
  localparam logic [6:0] I_ADDI    = 7'd4;
  localparam logic [6:0] I_LW      = 7'd5;
  localparam logic [6:0] I_SW      = 7'd6;
  localparam logic [6:0] I_BEQ     = 7'd7;
  localparam logic [6:0] I_JAL     = 7'd8;
  localparam logic [6:0] I_MUL     = 7'd16;
  localparam logic [6:0] I_MULH    = 7'd17;
  localparam logic [6:0] I_MULHSU  = 7'd18;
  localparam logic [6:0] I_MULHU   = 7'd19;
  localparam logic [6:0] I_MULW    = 7'd20;
  localparam logic [6:0] I_DIV     = 7'd24;
  localparam logic [6:0] I_DIVU    = 7'd25;
  localparam logic [6:0] I_REM     = 7'd26;
  localparam logic [6:0] I_REMU    = 7'd27;
  localparam logic [6:0] I_DIVW    = 7'd28;
  localparam logic [6:0] I_DIVUW   = 7'd29;
  localparam logic [6:0] I_REMW    = 7'd30;
  localparam logic [6:0] I_REMUW   = 7'd31;
endpackage

interface issue_ctrl_if;
  logic        id_valid;
  logic [6:0]  id_instr_id;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_w;
  logic        br_taken;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        issue;
  logic        stall;
  logic        flush;
  logic        md_start;
  logic        md_busy;
  logic        md_done;
  logic        illegal;
  logic [31:0] pending;

  modport master (
    output id_valid, id_instr_id, id_rs1, id_rs2, id_rd, id_reg_w,
           br_taken, wb_valid, wb_rd,
    input  issue, stall, flush, md_start, md_busy, md_done, illegal, pending
  );

  modport slave (
    input  id_valid, id_instr_id, id_rs1, id_rs2, id_rd, id_reg_w,
           br_taken, wb_valid, wb_rd,
    output issue, stall, flush, md_start, md_busy, md_done, illegal, pending
  );
endinterface

// File: rtl/issue_ctrl.sv
// Decode-to-execute issue controller: register-write scoreboard, mul/div
// busy sequencing, and branch/illegal squash of the decode slot.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 64
) (
  input logic         clk,
  input logic         rst_n,
  issue_ctrl_if.slave bus
);

  localparam int unsigned LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_state_e;

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             md_busy_q;
  logic             md_done_q;
  logic             illegal_q;
  logic             illegal_d;
  logic [31:0]      pending_q;
  logic [31:0]      pending_d;
  logic [31:0]      set_vec;
  logic [31:0]      clr_vec;
  logic             is_mul;
  logic             is_div;
  logic             is_bubble;
  logic             is_illegal;
  logic             hazard;
  logic             issue;
  logic             stall;
  logic             flush;

  assign is_mul = bus.id_instr_id inside {I_MUL, I_MULH, I_MULHSU, I_MULHU, I_MULW};
  assign is_div = bus.id_instr_id inside {I_DIV, I_DIVU, I_REM, I_REMU,
                                          I_DIVW, I_DIVUW, I_REMW, I_REMUW};
  assign is_bubble  = (bus.id_instr_id == I_BUBBLE);
  assign is_illegal = (bus.id_instr_id == I_INVALID);

  // Registered pending only: a register retiring this cycle unblocks next cycle.
  assign hazard = (pending_q[bus.id_rs1] && (bus.id_rs1 != 5'd0))
               || (pending_q[bus.id_rs2] && (bus.id_rs2 != 5'd0))
               || (bus.id_reg_w && (bus.id_rd != 5'd0) && pending_q[bus.id_rd]);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    issue     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    illegal_d = 1'b0;
    if (state_q != MD_IDLE) begin
      stall = bus.id_valid;
    end else if (bus.br_taken) begin
      flush = 1'b1;
    end else if (bus.id_valid && is_illegal) begin
      flush     = 1'b1;
      illegal_d = 1'b1;
    end else if (bus.id_valid && hazard) begin
      stall = 1'b1;
    end else begin
      issue = bus.id_valid && !is_bubble;
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue && bus.id_reg_w && (bus.id_rd != 5'd0)) set_vec[bus.id_rd] = 1'b1;
    if (bus.wb_valid) clr_vec[bus.wb_rd] = 1'b1;
    // Set is OR-ed in last so it wins over a same-cycle clear.
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      pending_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      illegal_q <= illegal_d;
    end
  end

  // md_done is registered, so it is raised on the step that loads cnt==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (issue && is_mul) begin
            state_q   <= MD_MUL;
            cnt_q     <= MUL_CNT;
            md_busy_q <= 1'b1;
            md_done_q <= (MUL_CNT == '0);
          end else if (issue && is_div) begin
            state_q   <= MD_DIV;
            cnt_q     <= DIV_CNT;
            md_busy_q <= 1'b1;
            md_done_q <= (DIV_CNT == '0);
          end else begin
            md_busy_q <= 1'b0;
            md_done_q <= 1'b0;
          end
        end
        MD_MUL, MD_DIV: begin
          if (cnt_q == '0) begin
            state_q   <= MD_IDLE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            md_done_q <= (cnt_q == CNT_W'(1));
          end
        end
        default: begin
          state_q   <= MD_IDLE;
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.issue    = issue;
  assign bus.stall    = stall;
  assign bus.flush    = flush;
  assign bus.md_start = issue && (is_mul || is_div);
  assign bus.md_busy  = md_busy_q;
  assign bus.md_done  = md_done_q;
  assign bus.illegal  = illegal_q;
  assign bus.pending  = pending_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: hazards, mul/div sequencing, branch and
// illegal squash, back-to-back issue and reset in the middle of a divide.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  issue_ctrl_if bus ();

  issue_ctrl #(.MUL_LAT(3), .DIV_LAT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] isf;
  logic [1:0] md;
  assign isf = {bus.issue, bus.stall, bus.flush};
  assign md  = {bus.md_busy, bus.md_done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_in();
    bus.id_valid    = 1'b0;
    bus.id_instr_id = I_BUBBLE;
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_rd       = 5'd0;
    bus.id_reg_w    = 1'b0;
    bus.br_taken    = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = 5'd0;
  endtask

  task automatic drive_id(input logic [6:0] id, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic reg_w);
    bus.id_valid    = 1'b1;
    bus.id_instr_id = id;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_reg_w    = reg_w;
  endtask

  task automatic retire(input logic [4:0] rd);
    tick();
    clear_in();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_in();
    tick();
    sample();
    n_cmp++;
    if ({md, bus.illegal, isf, bus.md_start} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got busy/done/ill/isf/start=%b want 0000000",
               {md, bus.illegal, isf, bus.md_start});
    end
    n_cmp++;
    if (bus.pending !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_pending: got %h want 00000000", bus.pending);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_raw();
    tick(); drive_id(I_ADD, 5'd1, 5'd2, 5'd5, 1'b1); sample();
    n_cmp++;
    if (isf !== 3'b100) begin n_bad++; $display("FAIL raw_add_issue: got isf=%b want 100", isf); end
    tick(); drive_id(I_SUB, 5'd5, 5'd0, 5'd6, 1'b1);
    for (int k = 0; k < 3; k++) begin
      sample();
      n_cmp++;
      if ({isf, bus.pending[5]} !== 4'b0101) begin
        n_bad++;
        $display("FAIL raw_stall[%0d]: got isf,p5=%b want 0101", k, {isf, bus.pending[5]});
      end
      tick();
    end
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; sample();
    n_cmp++;
    if ({isf, bus.pending[5]} !== 4'b0101) begin
      n_bad++;
      $display("FAIL raw_wb_cycle: got isf,p5=%b want 0101", {isf, bus.pending[5]});
    end
    tick(); bus.wb_valid = 1'b0; sample();
    n_cmp++;
    if ({isf, bus.pending[5]} !== 4'b1000) begin
      n_bad++;
      $display("FAIL raw_release: got isf,p5=%b want 1000", {isf, bus.pending[5]});
    end
    retire(5'd6);
    tick(); clear_in(); sample();
    n_cmp++;
    if (bus.pending !== 32'h0) begin n_bad++; $display("FAIL raw_clean: got %h want 00000000", bus.pending); end
  endtask

  task automatic test_x0();
    tick(); drive_id(I_ADDI, 5'd0, 5'd0, 5'd0, 1'b1); sample();
    n_cmp++;
    if (isf !== 3'b100) begin n_bad++; $display("FAIL x0_write: got isf=%b want 100", isf); end
    tick(); drive_id(I_ADD, 5'd0, 5'd0, 5'd0, 1'b1); sample();
    n_cmp++;
    if ({isf, bus.pending} !== {3'b100, 32'h0}) begin
      n_bad++;
      $display("FAIL x0_read: got isf=%b pending=%h want 100 00000000", isf, bus.pending);
    end
    tick(); clear_in(); sample();
    n_cmp++;
    if (bus.pending !== 32'h0) begin n_bad++; $display("FAIL x0_pending: got %h want 00000000", bus.pending); end
  endtask

  task automatic test_waw();
    tick(); drive_id(I_LW, 5'd1, 5'd0, 5'd7, 1'b1); sample();
    n_cmp++;
    if (isf !== 3'b100) begin n_bad++; $display("FAIL waw_lw: got isf=%b want 100", isf); end
    tick(); drive_id(I_ADDI, 5'd2, 5'd0, 5'd7, 1'b1); sample();
    n_cmp++;
    if ({isf, bus.pending} !== {3'b010, 32'h80}) begin
      n_bad++;
      $display("FAIL waw_stall: got isf=%b pending=%h want 010 00000080", isf, bus.pending);
    end
    tick(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; sample();
    n_cmp++;
    if (isf !== 3'b010) begin n_bad++; $display("FAIL waw_wb_cycle: got isf=%b want 010", isf); end
    tick(); bus.wb_valid = 1'b0; sample();
    n_cmp++;
    if ({isf, bus.pending} !== {3'b100, 32'h0}) begin
      n_bad++;
      $display("FAIL waw_release: got isf=%b pending=%h want 100 00000000", isf, bus.pending);
    end
    retire(5'd7); sample();
    n_cmp++;
    if (bus.pending !== 32'h80) begin n_bad++; $display("FAIL waw_reset_bit: got %h want 00000080", bus.pending); end
    tick(); clear_in(); sample();
    n_cmp++;
    if (bus.pending !== 32'h0) begin n_bad++; $display("FAIL waw_clean: got %h want 00000000", bus.pending); end
  endtask

  task automatic test_div();
    tick(); drive_id(I_DIV, 5'd1, 5'd2, 5'd8, 1'b1); sample();
    n_cmp++;
    if ({isf, bus.md_start, md} !== 6'b100100) begin
      n_bad++;
      $display("FAIL div_start: got isf,start,busy,done=%b want 100100", {isf, bus.md_start, md});
    end
    tick(); drive_id(I_ADD, 5'd3, 5'd4, 5'd9, 1'b1);
    for (int k = 1; k <= 64; k++) begin
      sample();
      n_cmp++;
      if ({md, isf} !== {1'b1, (k == 64), 3'b010}) begin
        n_bad++;
        $display("FAIL div_busy[+%0d]: got busy,done,isf=%b want %b", k, {md, isf},
                 {1'b1, (k == 64), 3'b010});
      end
      tick();
    end
    sample();
    n_cmp++;
    if ({isf, bus.md_start, md} !== 6'b100000) begin
      n_bad++;
      $display("FAIL div_next_issue: got isf,start,busy,done=%b want 100000", {isf, bus.md_start, md});
    end
    retire(5'd8);
    retire(5'd9);
    tick(); clear_in(); sample();
    n_cmp++;
    if (bus.pending !== 32'h0) begin n_bad++; $display("FAIL div_clean: got %h want 00000000", bus.pending); end
  endtask

  task automatic test_mul_branch();
    tick(); drive_id(I_MUL, 5'd1, 5'd2, 5'd10, 1'b1); sample();
    n_cmp++;
    if ({isf, bus.md_start} !== 4'b1001) begin
      n_bad++;
      $display("FAIL mul_start: got isf,start=%b want 1001", {isf, bus.md_start});
    end
    tick(); clear_in(); sample();
    n_cmp++;
    if (md !== 2'b10) begin n_bad++; $display("FAIL mul_busy1: got busy,done=%b want 10", md); end
    tick(); bus.br_taken = 1'b1; drive_id(I_ADD, 5'd1, 5'd2, 5'd11, 1'b1); sample();
    n_cmp++;
    if ({isf, md} !== 5'b01010) begin
      n_bad++;
      $display("FAIL mul_br_ignored: got isf,busy,done=%b want 01010", {isf, md});
    end
    tick(); bus.br_taken = 1'b0; sample();
    n_cmp++;
    if ({isf, md} !== 5'b01011) begin
      n_bad++;
      $display("FAIL mul_done: got isf,busy,done=%b want 01011", {isf, md});
    end
    tick(); sample();
    n_cmp++;
    if ({isf, md} !== 5'b10000) begin
      n_bad++;
      $display("FAIL mul_next_issue: got isf,busy,done=%b want 10000", {isf, md});
    end
    retire(5'd10);
    retire(5'd11);
    tick(); clear_in(); sample();
    n_cmp++;
    if (bus.pending !== 32'h0) begin n_bad++; $display("FAIL mul_clean: got %h want 00000000", bus.pending); end
  endtask

  task automatic test_branch_idle();
    tick(); bus.br_taken = 1'b1; drive_id(I_ADD, 5'd1, 5'd2, 5'd12, 1'b1); sample();
    n_cmp++;
    if ({isf, bus.md_start} !== 4'b0010) begin
      n_bad++;
      $display("FAIL br_flush: got isf,start=%b want 0010", {isf, bus.md_start});
    end
    tick(); clear_in(); sample();
    n_cmp++;
    if (bus.pending !== 32'h0) begin n_bad++; $display("FAIL br_no_issue: got %h want 00000000", bus.pending); end
  endtask

  task automatic test_illegal();
    tick(); drive_id(I_ADD, 5'd0, 5'd0, 5'd3, 1'b1); sample();
    tick(); drive_id(I_INVALID, 5'd1, 5'd2, 5'd4, 1'b1); sample();
    n_cmp++;
    if ({isf, bus.illegal, bus.pending} !== {3'b001, 1'b0, 32'h8}) begin
      n_bad++;
      $display("FAIL ill_flush: got isf=%b ill=%b pending=%h want 001 0 00000008",
               isf, bus.illegal, bus.pending);
    end
    tick(); clear_in(); sample();
    n_cmp++;
    if ({bus.illegal, bus.pending} !== {1'b1, 32'h8}) begin
      n_bad++;
      $display("FAIL ill_pulse: got ill=%b pending=%h want 1 00000008", bus.illegal, bus.pending);
    end
    retire(5'd3); sample();
    n_cmp++;
    if (bus.illegal !== 1'b0) begin n_bad++; $display("FAIL ill_one_cycle: got %b want 0", bus.illegal); end
    tick(); clear_in(); sample();
    n_cmp++;
    if (bus.pending !== 32'h0) begin n_bad++; $display("FAIL ill_clean: got %h want 00000000", bus.pending); end
  endtask

  task automatic test_back_to_back();
    for (int r = 1; r <= 4; r++) begin
      tick(); drive_id(I_ADD, 5'd0, 5'd0, 5'(r), 1'b1); sample();
      n_cmp++;
      if (isf !== 3'b100) begin n_bad++; $display("FAIL b2b_issue[%0d]: got isf=%b want 100", r, isf); end
    end
    tick(); drive_id(I_BUBBLE, 5'd0, 5'd0, 5'd0, 1'b0); sample();
    n_cmp++;
    if ({isf, bus.pending} !== {3'b000, 32'h1E}) begin
      n_bad++;
      $display("FAIL b2b_bubble: got isf=%b pending=%h want 000 0000001e", isf, bus.pending);
    end
    for (int r = 1; r <= 4; r++) retire(5'(r));
    tick(); clear_in(); sample();
    n_cmp++;
    if (bus.pending !== 32'h0) begin n_bad++; $display("FAIL b2b_clean: got %h want 00000000", bus.pending); end
  endtask

  task automatic test_reset_mid();
    tick(); drive_id(I_ADD, 5'd0, 5'd0, 5'd5, 1'b1);
    tick(); drive_id(I_ADD, 5'd0, 5'd0, 5'd7, 1'b1);
    tick(); drive_id(I_DIV, 5'd1, 5'd2, 5'd0, 1'b0); sample();
    n_cmp++;
    if (isf !== 3'b100) begin n_bad++; $display("FAIL rst_div_issue: got isf=%b want 100", isf); end
    tick(); clear_in();
    for (int k = 2; k <= 34; k++) tick();
    sample();
    n_cmp++;
    if ({md, bus.pending} !== {2'b10, 32'hA0}) begin
      n_bad++;
      $display("FAIL rst_pre: got busy,done=%b pending=%h want 10 000000a0", md, bus.pending);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({md, isf, bus.pending} !== {5'b00000, 32'h0}) begin
      n_bad++;
      $display("FAIL rst_async: got busy,done,isf=%b pending=%h want 00000 00000000",
               {md, isf}, bus.pending);
    end
    tick(); rst_n = 1'b1; drive_id(I_ADD, 5'd5, 5'd7, 5'd7, 1'b1); sample();
    n_cmp++;
    if (isf !== 3'b100) begin n_bad++; $display("FAIL rst_first_issue: got isf=%b want 100", isf); end
    tick(); clear_in(); sample();
    n_cmp++;
    if ({md, bus.pending} !== {2'b00, 32'h80}) begin
      n_bad++;
      $display("FAIL rst_after: got busy,done=%b pending=%h want 00 00000080", md, bus.pending);
    end
    retire(5'd7);
    tick(); clear_in();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear_in();
    test_reset();
    test_raw();
    test_x0();
    test_waw();
    test_div();
    test_mul_branch();
    test_branch_idle();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Decode-to-execute issue controller for the in-order RV64IM core. It sits between the instruction decoder and the execute stage. It keeps a 32-entry register-write scoreboard for RAW and WAW hazards, sequences the multi-cycle multiply/divide unit through a busy state machine, and squashes the decode slot on a taken branch. It owns all stall, flush and issue decisions for the decode stage.

## Interface
Parameters:
- MUL_LAT, 3: execute cycles for `i_mul`, `i_mulh`, `i_mulhsu`, `i_mulhu`, `i_mulw`; must be ≥1.
- DIV_LAT, 64: execute cycles for `i_div`, `i_divu`, `i_rem`, `i_remu`, `i_divw`, `i_divuw`, `i_remw`, `i_remuw`; must be ≥1.

Ports:
- clk in 1: core clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- id_valid in 1: decode slot holds an instruction.
- id_instr_id in 7: decoded instruction id (encodings from instructions.v).
- id_rs1 in 5: source register 1 of the decoded instruction.
- id_rs2 in 5: source register 2 of the decoded instruction.
- id_rd in 5: destination register; 0 for branches and stores.
- id_reg_w in 1: decoded instruction writes rd.
- br_taken in 1: execute stage resolved a taken branch or jump this cycle.
- wb_valid in 1: writeback is retiring a register write.
- wb_rd in 5: register being written back.
- issue out 1: decode instruction moves to execute this cycle (combinational).
- stall out 1: hold the fetch and decode registers (combinational).
- flush out 1: replace the decode slot with a bubble (combinational).
- md_start out 1: issued instruction is a mul/div op (combinational, equals issue & is_muldiv).
- md_busy out 1: mul/div FSM not IDLE (registered).
- md_done out 1: last cycle of the mul/div operation (registered).
- illegal out 1: one-cycle pulse, the previous cycle consumed an `i_invalid` instruction.
- pending out 32: scoreboard contents for debug; bit 0 is always 0.

## Operation
- Source check: rs1 and rs2 are always treated as read, which is conservative for U/J types. Register x0 never hazards.
- hazard = (pending[rs1] & rs1≠0) | (pending[rs2] & rs2≠0) | (id_reg_w & id_rd≠0 & pending[id_rd]).
- The hazard check uses the registered pending value only. There is no same-cycle bypass from wb, so a retiring register unblocks on the following cycle.
- is_bubble = (id_instr_id == `i_bubble).
- is_illegal = (id_instr_id == `i_invalid).
- Combinational priority:
  1. If FSM ≠ IDLE: issue=0, stall=id_valid, flush=0. br_taken is ignored.
  2. Else if br_taken: issue=0, stall=0, flush=1.
  3. Else if id_valid & is_illegal: issue=0, stall=0, flush=1 (the instruction is consumed), and illegal is set next cycle.
  4. Else if id_valid & hazard: issue=0, stall=1.
  5. Else: issue = id_valid & ~is_bubble, stall=0, flush=0.
- Scoreboard update per cycle: pending_next = (pending & ~clr) | set.
  - set = onehot(id_rd) when issue & id_reg_w & id_rd≠0.
  - clr = onehot(wb_rd) when wb_valid.
  - Set and clear of the same bit in the same cycle cannot occur because of the WAW stall. If it does occur, set wins.
- Mul/div FSM states: IDLE, MUL, DIV.
  - IDLE→MUL on issue of a mul-class op; cnt loads MUL_LAT−1.
  - IDLE→DIV on issue of a div/rem-class op; cnt loads DIV_LAT−1.
  - In MUL or DIV: if cnt==0, md_done=1 and the next state is IDLE; otherwise cnt decrements.
- cnt width is $clog2(max(MUL_LAT,DIV_LAT)+1), unsigned, with no wrap (the FSM exits at 0).
- Reset values: FSM=IDLE, cnt=0, pending=0, md_busy=0, md_done=0, illegal=0. Combinational outputs follow from these values.
- Reset mid-operation: an in-flight mul/div is abandoned, all pending bits clear, and the first post-reset instruction issues with no hazard.

## Timing
- Issue at cycle T of an op with latency L: md_busy is high for T+1..T+L, md_done is high at T+L, and the next issue is possible at T+L+1.
- With L=1: md_busy and md_done are both high at T+1 only.
- pending bit set: visible at T+1.
- Writeback at cycle W: the dependent instruction issues at W+1 at the earliest.
- br_taken at cycle B in IDLE: flush=1 at B, and the decode slot is not issued.
- illegal: high exactly one cycle, at T+1 after the consuming cycle T.
- Back-to-back independent ALU ops: one issue per cycle with no stall.

## Test plan
- Issue `i_add` rd=5, then `i_sub` rs1=5 → stall=1 until the wb_rd=5 pulse at cycle W; the `i_sub` issues at W+1; pending[5] is 1 from issue+1 through W and 0 at W+1.
- Issue `i_div` with DIV_LAT=64 at cycle 10 → md_start=1 at 10; md_busy high for cycles 11–74; md_done=1 at 74 only; the next independent op issues at 75 and stall=1 during 11–74.
- Issue `i_mul` (MUL_LAT=3), hold br_taken=1 at cycle T+2 → br_taken is ignored; flush=0; md_done at T+3.
- id_valid with `i_invalid` at cycle 20 → issue=0, flush=1 at 20; illegal=1 at 21 only; pending is unchanged.
- Write rd=0 via `i_addi`, then read rs1=0 → pending stays 0 and there is no stall. Also issue `i_lw` rd=7 followed by `i_addi` rd=7 (WAW) → stall until the wb of x7.
- Drop rst_n low for 1 cycle while in DIV with cnt=30 and pending=0x0000_00A0 → immediately md_busy=0, pending=0, FSM IDLE; the next valid op issues in the first cycle after rst_n returns high.
